// File: rtl/data_ram_ctrl_pkg.sv
// Shared definitions for the data RAM controller: FSM encoding, byte-lane
// select constants and default geometry/timing.
package data_ram_ctrl_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_WAIT_CYC = 2;
  localparam int CNT_W        = 4;   // wait-state counter holds 0..15

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Big-endian lane selects: bit 3 owns data[31:24], bit 0 owns data[7:0].
  localparam logic [3:0] LANE_B3   = 4'b1000;
  localparam logic [3:0] LANE_B2   = 4'b0100;
  localparam logic [3:0] LANE_B1   = 4'b0010;
  localparam logic [3:0] LANE_B0   = 4'b0001;
  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_ALL  = 4'b1111;

endpackage

// File: rtl/data_ram_array.sv
// Word-addressed storage built from four byte-wide banks. Writes are
// per-lane and synchronous; the read word is registered and can be cleared
// so the controller can return zero for an out-of-range access.
module data_ram_array
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] rd_word;
  logic [31:0] rdata_q;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] bank [DEPTH];

    // Byte bank write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
      if (we_i[g]) bank[addr_i] <= wdata_i[8*g +: 8];
    end

    assign rd_word[8*g +: 8] = bank[addr_i];
  end

  // Registered read word: cleared on error, loaded on a completed read, else held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rd_word;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller for the memory pipeline stage.
// Handshake: the requester raises ce_i with a stable request; stallreq_o is
// high from the request cycle until the access is performed, and the block
// works from latched copies only. ack_o pulses for one cycle when the
// access completes (err_o alongside it for an out-of-range address).
// flush_i cancels a request that has not yet completed.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  input  logic        flush_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [1:0]  state_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [31:2]        addr_q;
  logic [3:0]         sel_q;
  logic [31:0]        data_q;
  logic               err_q;

  logic               latch_en;
  logic               access;
  logic               stall;
  logic               in_range;
  logic [3:0]         lane_we;
  logic               rd_en;
  logic               rd_clr;

  // Byte offset within the word is ignored by design.
  logic               unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  assign in_range = (addr_q[31:ADDR_W+2] == '0);

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    access   = 1'b0;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ce_i && !flush_i) begin
          state_d  = ST_BUSY;
          cnt_d    = CNT_W'(WAIT_CYC);
          latch_en = 1'b1;
          stall    = 1'b1;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Latch the request when it is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (latch_en) begin
      we_q   <= we_i;
      addr_q <= addr_i[31:2];
      sel_q  <= sel_i;
      data_q <= data_i;
    end
  end

  // Remember whether the performed access was out of range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (access) begin
      err_q <= !in_range;
    end
  end

  assign lane_we = {4{access && we_q && in_range}} & sel_q;
  assign rd_en   = access && !we_q && in_range;
  assign rd_clr  = access && !in_range;

  data_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (lane_we),
    .re_i    (rd_en),
    .clr_i   (rd_clr),
    .addr_i  (addr_q[ADDR_W+1:2]),
    .wdata_i (data_q),
    .rdata_o (data_o)
  );

  // Stall is forced low while reset is asserted, even if ce_i is high.
  assign stallreq_o = stall && rst;
  assign ack_o      = (state_q == ST_DONE);
  assign err_o      = (state_q == ST_DONE) && err_q;
  assign state_o    = state_q;

endmodule

// File: doc/data_ram_ctrl.md
DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width (2^ADDR_W words of 32 bits).
REQ-002 SHALL have parameter WAIT_CYC, default 2, meaning extra wait states per access (0..15).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ce_i  in  1  request valid from memory stage.
REQ-006 SHALL have port we_i  in  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_i  in  32  byte address, word-aligned by requester.
REQ-008 SHALL have port sel_i  in  4  byte lanes, big-endian: sel_i[3]=data[31:24] ... sel_i[0]=data[7:0].
REQ-009 SHALL have port data_i  in  32  write data, pre-replicated per lane by requester.
REQ-010 SHALL have port flush_i  in  1  cancel the in-flight access (exception).
REQ-011 SHALL have port data_o  out  32  read data, registered.
REQ-012 SHALL have port stallreq_o  out  1  pipeline stall request.
REQ-013 SHALL have port ack_o  out  1  one-cycle access-complete pulse.
REQ-014 SHALL have port err_o  out  1  one-cycle out-of-range pulse, coincident with ack_o.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, DONE; encoding 2 bits.
REQ-016 IDLE: ce_i=1 SHALL latch we_i/addr_i/sel_i/data_i, load wait counter with WAIT_CYC, go BUSY; stallreq_o SHALL be combinationally 1 in that cycle.
REQ-017 BUSY: stallreq_o=1; counter!=0 -> decrement, stay; counter==0 -> perform access at that edge, go DONE.
REQ-018 DONE: stallreq_o=0, ack_o=1, data_o valid; unconditional return to IDLE; ce_i ignored in DONE.
REQ-019 Request at IDLE cycle T SHALL give ack_o at cycle T+WAIT_CYC+2; stallreq_o high T..T+WAIT_CYC+1.
REQ-020 Requester SHALL hold inputs stable while stallreq_o=1; block uses latched copies only.
REQ-021 Word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-022 Out-of-range (any addr[31:ADDR_W+2] nonzero): no write, data_o<=0, err_o=1 in DONE.
REQ-023 Write: only lanes with sel=1 updated; sel=4'b0000 SHALL change nothing yet still ack; data_o unchanged on writes.
REQ-024 Read: data_o<=full 32-bit word regardless of sel; held until next completed read or error.
REQ-025 flush_i=1 in BUSY SHALL return to IDLE next edge, no memory write, no ack_o, data_o unchanged; flush_i in IDLE suppresses request capture; flush_i in DONE has no effect.
REQ-026 ce_i=0 in IDLE SHALL keep IDLE, all strobes 0.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, counter 0, data_o 0, ack_o 0, err_o 0, stallreq_o 0, latched request 0.
REQ-028 Reset mid-BUSY SHALL abort the access with no write; memory array contents SHALL NOT be reset.

Structure
REQ-029 Shared package SHALL hold state encodings, lane-select constants, and default ADDR_W/WAIT_CYC.
REQ-030 Storage SHALL be sub-module data_ram_array: 4 byte-wide banks, per-lane write enable, synchronous write, registered read.
REQ-031 Controller (FSM, counter, range check, latching) SHALL remain in data_ram_ctrl; target 120-400 lines RTL total.

Verification
REQ-032 WAIT_CYC=2: write 0x11223344 sel 1111 addr 0x10 at T -> stallreq_o T..T+3, ack_o at T+4; read 0x10 -> data_o=0x11223344.
REQ-033 Byte write 0xAAAAAAAA sel 0100 addr 0x10 then read -> data_o=0x11AA3344.
REQ-034 Read addr 0x00010000 (ADDR_W=10) -> ack_o and err_o at T+4, data_o=0; write there alters no word.
REQ-035 flush_i at T+2 during write 0xDEADBEEF addr 0x20 -> no ack_o, back to IDLE at T+3; later read 0x20 returns prior contents.
REQ-036 rst low at T+1 of write addr 0x30 -> outputs 0 asynchronously, state IDLE, word 0x30 unchanged.
REQ-037 WAIT_CYC=0 back-to-back reads 0x10 then 0x14 -> acks at T+2 and T+5 (IDLE re-entered between).
